// File: rtl/riscv_fetch_buffer_if.sv
// Fetch-buffer bus bundle: redirect/trap control, instruction-memory channel
// and the instruction stream toward the core.
interface riscv_fetch_buffer_if;
  logic        start_valid;
  logic [31:0] start_pc;
  logic        trap;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;

  modport master (
    input  start_valid, start_pc, trap, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr, pc, instr_valid, busy
  );

  modport slave (
    output start_valid, start_pc, trap, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr, pc, instr_valid, busy
  );
endinterface

// File: rtl/riscv_fetch_buffer.sv
// Instruction prefetch buffer: one outstanding word fetch at a time into a
// DEPTH-entry {pc, instr} FIFO, with redirect, trap flush and response draining.
module riscv_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  riscv_fetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, STALL, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   redir_pc, redir_pc_nxt;
  logic          redir_pend, redir_pend_nxt;
  logic [31:0]   start_aligned;
  entry_t        fifo [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   post_cnt;
  logic          not_empty, push, pop, flush;

  assign start_aligned = bus.start_pc & ~32'h3;
  assign not_empty     = (count != '0);
  assign pop           = not_empty & bus.instr_ready;
  assign post_cnt      = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    redir_pc_nxt   = redir_pc;
    redir_pend_nxt = redir_pend;
    push           = 1'b0;
    flush          = 1'b0;
    if (bus.trap) begin
      flush          = 1'b1;
      redir_pend_nxt = 1'b0;
      // Stay in DRAIN while a response is still owed, otherwise it would be
      // mistaken for the reply to the next request.
      unique case (state)
        REQ:          state_nxt = bus.mem_gnt    ? DRAIN : IDLE;
        WAIT, DRAIN:  state_nxt = bus.mem_rvalid ? IDLE  : DRAIN;
        default:      state_nxt = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_valid) begin
            fetch_pc_nxt = start_aligned;
            state_nxt    = REQ;
          end
        end
        REQ: begin
          if (bus.start_valid) begin
            flush = 1'b1;
            if (bus.mem_gnt) begin
              redir_pc_nxt   = start_aligned;
              redir_pend_nxt = 1'b1;
              state_nxt      = DRAIN;
            end else begin
              fetch_pc_nxt = start_aligned;
            end
          end else if (bus.mem_gnt) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (bus.start_valid) begin
            flush = 1'b1;
            // A response landing on this same edge leaves nothing to drain.
            if (bus.mem_rvalid) begin
              fetch_pc_nxt = start_aligned;
              state_nxt    = REQ;
            end else begin
              redir_pc_nxt   = start_aligned;
              redir_pend_nxt = 1'b1;
              state_nxt      = DRAIN;
            end
          end else if (bus.mem_rvalid) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
            state_nxt    = (post_cnt < {1'b0, DEPTH_C}) ? REQ : STALL;
          end
        end
        STALL: begin
          if (bus.start_valid) begin
            flush        = 1'b1;
            fetch_pc_nxt = start_aligned;
            state_nxt    = REQ;
          end else if (count < DEPTH_C) begin
            state_nxt = REQ;
          end
        end
        DRAIN: begin
          if (bus.start_valid) begin
            redir_pc_nxt   = start_aligned;
            redir_pend_nxt = 1'b1;
          end
          if (bus.mem_rvalid) begin
            redir_pend_nxt = 1'b0;
            if (bus.start_valid || redir_pend) begin
              fetch_pc_nxt = bus.start_valid ? start_aligned : redir_pc;
              state_nxt    = REQ;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.busy     = (state != IDLE);
    if (state == REQ) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc   <= '0;
      redir_pc   <= '0;
      redir_pend <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      fetch_pc   <= fetch_pc_nxt;
      redir_pc   <= redir_pc_nxt;
      redir_pend <= redir_pend_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: fetch_pc, instr: bus.mem_rdata};
  end

  assign bus.instr_valid = not_empty;
  assign bus.instr       = not_empty ? fifo[rd_ptr].instr : '0;
  assign bus.pc          = not_empty ? fifo[rd_ptr].pc    : '0;
endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Fetch buffer bench: memory responder plus in-order stream scoreboard
// (expected pc advances by 4, data is a fixed function of the address).
module tb_riscv_fetch_buffer;
  logic clk = 1'b0;
  logic reset;
  riscv_fetch_buffer_if bus();

  riscv_fetch_buffer #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int p_gnt = 100, p_ready = 100, lat_min = 0, lat_max = 0;
  bit rst_drv = 1'b0;
  bit outstanding = 1'b0;
  logic [31:0] out_addr = '0;
  int lat = 0, grants = 0, pops = 0;
  bit active = 1'b0, cap = 1'b0, hold = 1'b0;
  logic [31:0] exp_pc = '0, hold_addr = '0, first_pc = '0;
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'hDEADBEEF) + {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_mem_req"}, bus.mem_req, 1'b0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_instr"}, bus.instr, 32'h0);
    chk({tag, "_pc"}, bus.pc, 32'h0);
    chk1({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  // One clock: observe outputs, play memory and core, then update the model.
  task automatic step(input bit sv, input logic [31:0] spc, input bit tr);
    logic rq, iv;
    logic [31:0] ad, ipc, ins;
    bit g, r;
    rq = bus.mem_req; ad = bus.mem_addr; iv = bus.instr_valid; ipc = bus.pc; ins = bus.instr;
    if (rq === 1'b1) begin
      chk("addr_align", ad & 32'h3, 32'h0);
      chk1("one_outstanding", outstanding, 1'b0);
    end
    if (hold) begin
      chk1("req_hold", rq, 1'b1);
      chk("addr_hold", ad, hold_addr);
    end
    g = ($urandom_range(99) < p_gnt);
    r = ($urandom_range(99) < p_ready);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    if (outstanding) begin
      if (lat == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = memf(out_addr);
        outstanding    = 1'b0;
      end else lat--;
    end
    hold = 1'b0;
    if (rq === 1'b1 && g) begin
      outstanding = 1'b1;
      out_addr    = ad;
      lat         = $urandom_range(lat_max, lat_min);
      grants++;
    end else if (rq === 1'b1 && !sv && !tr && rst_drv) begin
      hold      = 1'b1;
      hold_addr = ad;
    end
    if (iv === 1'b1 && r) begin
      if (active) begin
        chk("pop_pc", ipc, exp_pc);
        chk("pop_instr", ins, memf(exp_pc));
        pop_log.push_back(ipc);
        if (cap) begin first_pc = ipc; cap = 1'b0; end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end else chk1("pop_when_stopped", iv, 1'b0);
    end
    if (!rst_drv || tr) active = 1'b0;
    else if (sv) begin
      active = 1'b1;
      exp_pc = spc & ~32'h3;
      cap    = 1'b1;
    end
    bus.mem_gnt     = g;
    bus.instr_ready = r;
    bus.start_valid = sv;
    bus.start_pc    = spc;
    bus.trap        = tr;
    reset           = rst_drv;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic wait_grant(input string tag);
    int g0;
    g0 = grants;
    for (int k = 0; k < 20 && grants == g0; k++) idle(1);
    chk1({tag, "_grant_seen"}, grants != g0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, rp;
    bus.start_valid = 0; bus.start_pc = 0; bus.trap = 0; bus.mem_gnt = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.instr_ready = 0; reset = 0;
    @(posedge clk); #1;

    // Reset state
    rst_drv = 1'b0; idle(2); rst_drv = 1'b1;
    chk_reset_outputs("reset");

    // Streaming, gnt always, rvalid one cycle after grant
    p_gnt = 100; p_ready = 100; lat_min = 0; lat_max = 0;
    pop_log.delete();
    step(1'b1, 32'h80000000, 1'b0);
    chk1("stream_busy", bus.busy, 1'b1);
    idle(30);
    chk1("stream_count", pop_log.size() >= 8, 1'b1);
    chk("stream_first", pop_log[0], 32'h80000000);
    step(1'b0, 32'h0, 1'b1); idle(5);

    // Backpressure: exactly DEPTH grants, then one per pop
    p_ready = 0;
    g0 = grants;
    step(1'b1, 32'h00000100, 1'b0);
    idle(20);
    chk("bp_grants", grants - g0, 32'd4);
    chk1("bp_mem_req", bus.mem_req, 1'b0);
    chk1("bp_busy", bus.busy, 1'b1);
    chk1("bp_valid", bus.instr_valid, 1'b1);
    g0 = grants;
    p_ready = 100; idle(1); p_ready = 0;
    idle(10);
    chk("bp_refill", grants - g0, 32'd1);
    p_ready = 100; idle(15);
    step(1'b0, 32'h0, 1'b1); idle(5);

    // Trap while a response is pending
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h00000400, 1'b0);
    wait_grant("trap");
    step(1'b0, 32'h0, 1'b1);
    chk1("trap_valid", bus.instr_valid, 1'b0);
    chk1("trap_req", bus.mem_req, 1'b0);
    chk1("trap_drain_busy", bus.busy, 1'b1);
    for (int k = 0; k < 10 && outstanding; k++) idle(1);
    chk1("trap_busy_after", bus.busy, 1'b0);
    chk1("trap_valid_after", bus.instr_valid, 1'b0);
    idle(3);
    chk1("trap_no_push", bus.instr_valid, 1'b0);

    // Redirect mid-stream to an unaligned pc
    p_gnt = 70; p_ready = 80; lat_min = 0; lat_max = 2;
    step(1'b1, 32'h00002000, 1'b0);
    idle(12);
    first_pc = 32'hDEAD0001;
    step(1'b1, 32'h00001002, 1'b0);
    idle(25);
    chk("redir_first_pc", first_pc, 32'h00001000);
    step(1'b0, 32'h0, 1'b1); idle(6);

    // Address wrap
    p_gnt = 100; p_ready = 100; lat_max = 0;
    pop_log.delete();
    step(1'b1, 32'hFFFFFFF8, 1'b0);
    idle(12);
    chk1("wrap_count", pop_log.size() >= 3, 1'b1);
    chk("wrap_pc0", pop_log[0], 32'hFFFFFFF8);
    chk("wrap_pc1", pop_log[1], 32'hFFFFFFFC);
    chk("wrap_pc2", pop_log[2], 32'h00000000);
    step(1'b0, 32'h0, 1'b1); idle(5);

    // Reset during WAIT, late response must be ignored
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h00003000, 1'b0);
    wait_grant("rst");
    rst_drv = 1'b0; idle(1); rst_drv = 1'b1;
    chk_reset_outputs("midrst");
    for (int k = 0; k < 10 && outstanding; k++) idle(1);
    idle(2);
    chk_reset_outputs("late_rvalid");

    // Randomized traffic with random redirects and traps
    lat_min = 0; lat_max = 3;
    rp = pops;
    for (int i = 0; i < 2500; i++) begin
      bit sv, tr;
      if (i % 200 == 0) begin
        p_gnt   = $urandom_range(100, 30);
        p_ready = $urandom_range(100, 20);
      end
      sv = (!active && $urandom_range(9) == 0) || ($urandom_range(99) == 0);
      tr = ($urandom_range(199) == 0);
      step(sv, $urandom, tr);
    end
    chk1("random_progress", (pops - rp) > 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
